wb_arbiter: RTL and testbench

// Writeback stage of the dual-issue core; drives both write ports of the register file.

---
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Purpose: writeback arbiter that merges ALU lanes A/B and buffered load returns onto two register-file write ports.
// Latency: registered outputs, so a result presented in cycle N is written at N+1. A load pushed in N drains at N+1 or later.
// Backpressure: the ALU lanes are always accepted. Loads handshake through ld_rdy_o, which is taken from the registered FIFO count.
//
// Ports:
//   clk, reset (async, active-low), flush_i (sync load-FIFO flush)
//   aluA_*/aluB_*  : ALU lane results (lane B is younger than lane A)
//   ld_*           : load return valid/ready handshake, destination and data
//   we_o[1]/[0]    : enables for port A / port B; ad3A/wd3A and ad3B/wd3B are address/data
//   lq_count_o     : load FIFO occupancy; wb_count_o : count of retired writes (wraps)
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LQ_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          aluA_vld_i,
  input  logic [ADDR_WIDTH-1:0]         aluA_rd_i,
  input  logic [DATA_WIDTH-1:0]         aluA_res_i,
  input  logic                          aluB_vld_i,
  input  logic [ADDR_WIDTH-1:0]         aluB_rd_i,
  input  logic [DATA_WIDTH-1:0]         aluB_res_i,
  input  logic                          ld_vld_i,
  output logic                          ld_rdy_o,
  input  logic [ADDR_WIDTH-1:0]         ld_rd_i,
  input  logic [DATA_WIDTH-1:0]         ld_data_i,
  output logic [1:0]                    we_o,
  output logic [ADDR_WIDTH-1:0]         ad3A_o,
  output logic [DATA_WIDTH-1:0]         wd3A_o,
  output logic [ADDR_WIDTH-1:0]         ad3B_o,
  output logic [DATA_WIDTH-1:0]         wd3B_o,
  output logic [$clog2(LQ_DEPTH):0]     lq_count_o,
  output logic [31:0]                   wb_count_o
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Load-return FIFO storage and bookkeeping
  logic [ADDR_WIDTH-1:0] lq_rd   [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] lq_data [LQ_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr, nxt_ptr;
  logic [CNT_W-1:0]      lq_cnt;

  logic                  a_v, b_v, push, has1, has2;
  logic                  pa_en, pb_en;
  logic [ADDR_WIDTH-1:0] pa_rd, pb_rd;
  logic [DATA_WIDTH-1:0] pa_dat, pb_dat;
  logic [1:0]            pop_n;

  assign ld_rdy_o   = (lq_cnt < CNT_W'(LQ_DEPTH));
  assign lq_count_o = lq_cnt;

  // Writes to x0 are discarded at the input. A load to x0 still completes its handshake.
  assign a_v     = aluA_vld_i && (aluA_rd_i != '0);
  assign b_v     = aluB_vld_i && (aluB_rd_i != '0);
  assign push    = ld_vld_i && ld_rdy_o && (ld_rd_i != '0) && !flush_i;
  assign nxt_ptr = rd_ptr + PTR_W'(1);

  // A flush discards the FIFO contents, so nothing drains in the flush cycle.
  assign has1 = (lq_cnt != '0) && !flush_i;
  assign has2 = (lq_cnt >= CNT_W'(2)) && !flush_i;

  always_comb begin
    pa_en  = 1'b0;
    pa_rd  = '0;
    pa_dat = '0;
    pb_en  = 1'b0;
    pb_rd  = '0;
    pb_dat = '0;
    pop_n  = 2'd0;

    // Port A: lane A first, otherwise the FIFO head.
    if (a_v) begin
      pa_en  = 1'b1;
      pa_rd  = aluA_rd_i;
      pa_dat = aluA_res_i;
    end else if (has1) begin
      pa_en  = 1'b1;
      pa_rd  = lq_rd[rd_ptr];
      pa_dat = lq_data[rd_ptr];
      pop_n  = 2'd1;
    end

    // Port B: lane B first. Otherwise it takes head+1 when port A already took the head, or the head itself.
    if (b_v) begin
      pb_en  = 1'b1;
      pb_rd  = aluB_rd_i;
      pb_dat = aluB_res_i;
    end else if (!a_v) begin
      if (has2) begin
        pb_en  = 1'b1;
        pb_rd  = lq_rd[nxt_ptr];
        pb_dat = lq_data[nxt_ptr];
        pop_n  = 2'd2;
      end
    end else if (has1) begin
      pb_en  = 1'b1;
      pb_rd  = lq_rd[rd_ptr];
      pb_dat = lq_data[rd_ptr];
      pop_n  = 2'd1;
    end

    // Same-rd collision: the older write is dropped but still retired.
    // Port B carries the younger write in every case except lane A against a FIFO entry on port B.
    if (pa_en && pb_en && (pa_rd == pb_rd)) begin
      if (a_v && !b_v) pb_en = 1'b0;
      else             pa_en = 1'b0;
    end
  end

  // FIFO storage has no reset. Occupancy is tracked by the pointers and the count.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[wr_ptr]   <= ld_rd_i;
      lq_data[wr_ptr] <= ld_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      lq_cnt <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      lq_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      lq_cnt <= lq_cnt + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_o       <= 2'b00;
      ad3A_o     <= '0;
      wd3A_o     <= '0;
      ad3B_o     <= '0;
      wd3B_o     <= '0;
      wb_count_o <= '0;
    end else begin
      we_o       <= {pa_en, pb_en};
      ad3A_o     <= pa_en ? pa_rd  : '0;
      wd3A_o     <= pa_en ? pa_dat : '0;
      ad3B_o     <= pb_en ? pb_rd  : '0;
      wd3B_o     <= pb_en ? pb_dat : '0;
      wb_count_o <= wb_count_o + 32'(pa_en) + 32'(pb_en);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Purpose: directed self-checking bench for wb_arbiter.
// Latency: inputs are applied 1ns after a rising edge, and outputs are checked 1ns after the next edge.
// Backpressure: loads are issued only through the ld_vld_i/ld_rdy_o handshake, with both stalled and ready cases.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        aluA_vld_i, aluB_vld_i, ld_vld_i;
  logic [4:0]  aluA_rd_i, aluB_rd_i, ld_rd_i;
  logic [31:0] aluA_res_i, aluB_res_i, ld_data_i;
  logic        ld_rdy_o;
  logic [1:0]  we_o;
  logic [4:0]  ad3A_o, ad3B_o;
  logic [31:0] wd3A_o, wd3B_o;
  logic [2:0]  lq_count_o;
  logic [31:0] wb_count_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .aluA_vld_i(aluA_vld_i), .aluA_rd_i(aluA_rd_i), .aluA_res_i(aluA_res_i),
    .aluB_vld_i(aluB_vld_i), .aluB_rd_i(aluB_rd_i), .aluB_res_i(aluB_res_i),
    .ld_vld_i(ld_vld_i), .ld_rdy_o(ld_rdy_o), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
    .we_o(we_o), .ad3A_o(ad3A_o), .wd3A_o(wd3A_o), .ad3B_o(ad3B_o), .wd3B_o(wd3B_o),
    .lq_count_o(lq_count_o), .wb_count_o(wb_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bres,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    aluA_vld_i = av; aluA_rd_i = ard; aluA_res_i = ares;
    aluB_vld_i = bv; aluB_rd_i = brd; aluB_res_i = bres;
    ld_vld_i   = lv; ld_rd_i   = lrd; ld_data_i  = ldat;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Both lanes busy so nothing drains, optionally with a load offered.
  task automatic busy_load(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    drive(1, 5'd18, 32'h18, 1, 5'd19, 32'h19, lv, lrd, ldat);
  endtask

  initial begin
    reset = 1'b0;
    flush_i = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    // Reset values
    chk("rst_we", we_o, 2'b00);
    chk("rst_cnt", lq_count_o, 0);
    chk("rst_wb", wb_count_o, 0);
    chk("rst_rdy", ld_rdy_o, 1);
    chk("rst_adA", ad3A_o, 0);

    // Test 1: hold three loads with both lanes busy, then reset mid-operation
    drive(1, 5'd10, 32'h100, 1, 5'd11, 32'h101, 1, 5'd1, 32'h1);
    tick();
    chk("t1_we", we_o, 2'b11);
    chk("t1_adA", ad3A_o, 10);
    chk("t1_wdA", wd3A_o, 32'h100);
    chk("t1_adB", ad3B_o, 11);
    chk("t1_cnt1", lq_count_o, 1);
    ld_rd_i = 5'd2;
    tick();
    ld_rd_i = 5'd3;
    tick();
    chk("t1_cnt3", lq_count_o, 3);
    chk("t1_wb6", wb_count_o, 6);
    idle();
    #1 reset = 1'b0;
    #1;
    chk("t1_rst_we", we_o, 2'b00);
    chk("t1_rst_cnt", lq_count_o, 0);
    chk("t1_rst_wb", wb_count_o, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("t1_rdy", ld_rdy_o, 1);
    chk("t1_cnt_after", lq_count_o, 0);
    chk("t1_we_after", we_o, 2'b00);

    // Test 2: lane A to x5, lane B to x0 is dropped, and the FIFO head x7 goes to port B
    drive(1, 5'd12, 32'h1, 1, 5'd13, 32'h2, 1, 5'd7, 32'h22);
    tick();
    chk("t2_cnt1", lq_count_o, 1);
    chk("t2_wb2", wb_count_o, 2);
    drive(1, 5'd5, 32'h11, 1, 5'd0, 32'hdead, 0, 0, 0);
    tick();
    chk("t2_we", we_o, 2'b11);
    chk("t2_adA", ad3A_o, 5);
    chk("t2_wdA", wd3A_o, 32'h11);
    chk("t2_adB", ad3B_o, 7);
    chk("t2_wdB", wd3B_o, 32'h22);
    chk("t2_cnt0", lq_count_o, 0);
    chk("t2_wb4", wb_count_o, 4);

    // Test 3: two loads drain in a single cycle with both lanes idle
    drive(1, 5'd14, 32'h0, 1, 5'd15, 32'h0, 1, 5'd3, 32'hA);
    tick();
    drive(1, 5'd14, 32'h0, 1, 5'd15, 32'h0, 1, 5'd4, 32'hB);
    tick();
    chk("t3_cnt2", lq_count_o, 2);
    idle();
    tick();
    chk("t3_we", we_o, 2'b11);
    chk("t3_adA", ad3A_o, 3);
    chk("t3_wdA", wd3A_o, 32'hA);
    chk("t3_adB", ad3B_o, 4);
    chk("t3_wdB", wd3B_o, 32'hB);
    chk("t3_cnt0", lq_count_o, 0);
    chk("t3_wb10", wb_count_o, 10);

    // Test 4: same-rd collision between the lanes, so lane B wins
    drive(1, 5'd9, 32'h1, 1, 5'd9, 32'h2, 0, 0, 0);
    tick();
    chk("t4_we", we_o, 2'b01);
    chk("t4_adB", ad3B_o, 9);
    chk("t4_wdB", wd3B_o, 32'h2);
    chk("t4_wb11", wb_count_o, 11);
    drive(1, 5'd16, 32'h0, 1, 5'd17, 32'h0, 1, 5'd9, 32'h33);
    tick();
    chk("t4_cnt1", lq_count_o, 1);
    // The head x9 is older than lane B x9. It is suppressed but still popped.
    drive(0, 0, 0, 1, 5'd9, 32'h44, 0, 0, 0);
    tick();
    chk("t4b_we", we_o, 2'b01);
    chk("t4b_wdB", wd3B_o, 32'h44);
    chk("t4b_cnt0", lq_count_o, 0);
    chk("t4b_wb14", wb_count_o, 14);

    // Test 5: fill to depth. An extra load is refused, and freeing a port reopens the FIFO.
    for (int i = 0; i < 4; i++) begin
      busy_load(1, 5'(20 + i), 32'h50 + 32'(i));
      tick();
    end
    chk("t5_cnt4", lq_count_o, 4);
    chk("t5_rdy0", ld_rdy_o, 0);
    chk("t5_wb22", wb_count_o, 22);
    busy_load(1, 5'd24, 32'h99);
    tick();
    chk("t5_cnt_hold", lq_count_o, 4);
    chk("t5_rdy_hold", ld_rdy_o, 0);
    drive(1, 5'd18, 32'h18, 0, 0, 0, 1, 5'd24, 32'h99);
    tick();
    chk("t5_we", we_o, 2'b11);
    chk("t5_adB", ad3B_o, 20);
    chk("t5_wdB", wd3B_o, 32'h50);
    chk("t5_cnt3", lq_count_o, 3);
    chk("t5_rdy1", ld_rdy_o, 1);
    idle();
    tick();
    chk("t5_drain_adA", ad3A_o, 21);
    chk("t5_drain_adB", ad3B_o, 22);
    chk("t5_drain_wdB", wd3B_o, 32'h52);
    chk("t5_drain_cnt", lq_count_o, 1);
    tick();
    chk("t5_last_we", we_o, 2'b10);
    chk("t5_last_wdA", wd3A_o, 32'h53);
    chk("t5_last_cnt", lq_count_o, 0);
    tick();
    chk("t5_empty_we", we_o, 2'b00);
    chk("t5_wb29", wb_count_o, 29);

    // Test 6: flush while a load is offered
    busy_load(1, 5'd25, 32'h60);
    tick();
    busy_load(1, 5'd26, 32'h61);
    tick();
    chk("t6_cnt2", lq_count_o, 2);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd27, 32'h70);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    idle();
    chk("t6_cnt0", lq_count_o, 0);
    chk("t6_we0", we_o, 2'b00);
    tick();
    chk("t6_we_after", we_o, 2'b00);
    chk("t6_wb33", wb_count_o, 33);

    // A load to x0 completes its handshake but is not enqueued
    busy_load(1, 5'd0, 32'h77);
    tick();
    chk("x0_cnt", lq_count_o, 0);
    chk("x0_wb35", wb_count_o, 35);
    idle();
    tick();
    chk("x0_we", we_o, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
